wb_stage_buffered: RTL and testbench
====================================

Name: wb_stage_buffered

Overview:
Registered writeback stage for the RV32IM pipeline, and the successor to the combinational result mux. It is parametrised in datapath width. It adds:
- a MEM/WB pipeline register;
- load byte/half extraction with sign or zero extension;
- a one-entry buffer that merges late multi-cycle divide results into free writeback slots.

It sits between the MEM stage/data memory and the register file write port, and it also drives forwarding data to EX.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
RADDR_W, 5, register address width
OFF_W, $clog2(XLEN/8), byte-offset width (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_valid  in  1  MEM-stage instruction valid this cycle
flush  in  1  kill the incoming MEM-stage instruction this cycle
reg_write  in  1  instruction writes rd
rd  in  RADDR_W  destination register
res_sel  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
alu_out  in  XLEN  ALU result
pc_plus4  in  XLEN  PC+4
immediate  in  XLEN  U-type immediate
mem_rdata  in  XLEN  raw aligned memory word
byte_off  in  OFF_W  load address low bits
ld_funct3  in  3  load funct3
div_valid  in  1  divider result available
div_rd  in  RADDR_W  divider destination register
div_result  in  XLEN  divider result
div_ready  out  1  buffer can accept a divider result
div_pending  out  1  buffer occupied
div_pending_rd  out  RADDR_W  rd held in the buffer
rf_we  out  1  register file write enable
rf_waddr  out  RADDR_W  register file write address
rf_wdata  out  XLEN  register file write data

Behaviour:
- Reset: rf_we=0, rf_waddr=0, rf_wdata=0; buffer empty (div_pending=0, div_pending_rd=0); div_ready=1.
- Pipe slot: pipe_w = mem_valid & !flush & reg_write & (rd!=0).
- Latency: inputs sampled at edge N appear on rf_* after edge N, i.e. one cycle. All outputs except div_ready are registered.
- Load extraction (res_sel=01), byte lane = byte_off:
  - 000 LB: sign-extend byte[byte_off].
  - 100 LBU: zero-extend byte[byte_off].
  - 001 LH / 101 LHU: halfword at byte_off with bit0 ignored; sign- or zero-extend respectively.
  - 010 LW: word at byte_off[OFF_W-1:2] (0 when XLEN=32); sign-extended when XLEN=64.
  - XLEN=64 only: 110 LWU zero-extends the word; 011 LD passes the full doubleword.
  - Any other code: behaves as LW.
- Divider handshake:
  - div_ready = !div_pending | !pipe_w, combinational. The result is accepted when div_valid & div_ready.
- Slot arbitration, each cycle:
  - pipe_w=1: pipeline write wins.
    - If div_valid is asserted while the buffer is empty, the divide result is captured into the buffer.
    - If the buffer is full, div_ready=0 and the divider must hold.
  - pipe_w=0, buffer full: the buffered result is written. Buffer empties; a same-cycle div_valid refills it.
  - pipe_w=0, buffer empty, div_valid=1: the divide result is written directly, bypassing the buffer.
  - Otherwise: rf_we=0, and rf_waddr/rf_wdata hold their previous values.
- Writes to x0 never assert rf_we; a div_rd of 0 is accepted and then discarded.
- flush affects only the incoming MEM instruction. The buffer and divider results are never flushed.
- WAW ordering between the buffer and younger instructions is guaranteed upstream by the scoreboard using div_pending/div_pending_rd. This block performs no check.
- rst asserted mid-operation discards a buffered result. The divider is reset by the same rst.

Optional Feature:
WB_RETIRE_CNT_EN:
- Defined: adds output instret (64 bits), reset to 0. It increments by 1 on every cycle with mem_valid & !flush, regardless of reg_write, and wraps modulo 2^64.
- Undefined: the port and the counter are absent.

Test Plan:
- LB sign extension: XLEN=32, mem_rdata=0x80FF7F01, byte_off=3, funct3=000, rd=5, valid → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xFFFFFF80.
- LHU/LH: same word, byte_off=2, funct3=101 → rf_wdata=0x000080FF; funct3=001 → 0xFFFF80FF.
- Contention: pipeline writes rd=3 every cycle; div_valid with rd=7, result 0x2A → div_pending=1. Next cycle div_ready=0 with a second div_valid held. First bubble → rf_waddr=7, rf_wdata=0x2A; then the held result is captured.
- Flush/x0: flush=1 with rd=9 → rf_we=0 next cycle. reg_write with rd=0 → rf_we=0.
- Direct bypass: idle pipeline, div_valid with rd=12, result 0x1234 → rf_we=1, rf_waddr=12, rf_wdata=0x1234 after one edge; div_pending stays 0.
- Reset: buffer full, then rst for 1 cycle → div_pending=0, rf_we=0, div_ready=1. With WB_RETIRE_CNT_EN defined: 10 valid instructions including 2 flushed → instret=8.

Source files
------------

// File: rtl/wb_stage_buffered.sv
// Registered RV32IM/RV64IM writeback stage: MEM/WB register, load extraction and a one-entry divide buffer.
// Optional retire counter (output instret) is built when WB_RETIRE_CNT_EN is defined.
module wb_stage_buffered #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int OFF_W   = $clog2(XLEN / 8)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_valid,
    input  logic               flush,
    input  logic               reg_write,
    input  logic [RADDR_W-1:0] rd,
    input  logic [1:0]         res_sel,
    input  logic [XLEN-1:0]    alu_out,
    input  logic [XLEN-1:0]    pc_plus4,
    input  logic [XLEN-1:0]    immediate,
    input  logic [XLEN-1:0]    mem_rdata,
    input  logic [OFF_W-1:0]   byte_off,
    input  logic [2:0]         ld_funct3,
    input  logic               div_valid,
    input  logic [RADDR_W-1:0] div_rd,
    input  logic [XLEN-1:0]    div_result,
    output logic               div_ready,
    output logic               div_pending,
    output logic [RADDR_W-1:0] div_pending_rd,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]        instret,
`endif
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata
);

    logic               pipe_w;
    logic               div_keep;
    logic [XLEN-1:0]    byte_sh, half_sh, word_sh;
    logic [7:0]         lane_b;
    logic [15:0]        lane_h;
    logic [31:0]        lane_w;
    logic [XLEN-1:0]    load_val;
    logic [XLEN-1:0]    pipe_data;

    logic               rf_we_d, rf_we_q;
    logic [RADDR_W-1:0] rf_waddr_d, rf_waddr_q;
    logic [XLEN-1:0]    rf_wdata_d, rf_wdata_q;
    logic               buf_valid_d, buf_valid_q;
    logic [RADDR_W-1:0] buf_rd_d, buf_rd_q;
    logic [XLEN-1:0]    buf_data_d, buf_data_q;

    assign pipe_w    = mem_valid & ~flush & reg_write & (rd != {RADDR_W{1'b0}});
    // A divide result for x0 is still handshaken but never occupies a slot or the buffer.
    assign div_keep  = div_valid & (div_rd != {RADDR_W{1'b0}});
    assign div_ready = ~buf_valid_q | ~pipe_w;

    // Lane selection: halfword ignores offset bit 0, word ignores offset bits [1:0].
    always_comb begin
        byte_sh = mem_rdata >> {byte_off, 3'b000};
        half_sh = mem_rdata >> {(byte_off & ~OFF_W'(1'b1)), 3'b000};
        word_sh = mem_rdata >> {(byte_off & ~OFF_W'(2'b11)), 3'b000};
        lane_b  = byte_sh[7:0];
        lane_h  = half_sh[15:0];
        lane_w  = word_sh[31:0];
    end

    // Load extension by funct3; unknown codes fall back to LW behaviour.
    always_comb begin
        case (ld_funct3)
            3'b000:  load_val = XLEN'($signed(lane_b));
            3'b100:  load_val = XLEN'(lane_b);
            3'b001:  load_val = XLEN'($signed(lane_h));
            3'b101:  load_val = XLEN'(lane_h);
            3'b010:  load_val = XLEN'($signed(lane_w));
            3'b110:  load_val = (XLEN == 64) ? XLEN'(lane_w) : XLEN'($signed(lane_w));
            3'b011:  load_val = (XLEN == 64) ? mem_rdata : XLEN'($signed(lane_w));
            default: load_val = XLEN'($signed(lane_w));
        endcase
    end

    // Result select for the pipeline instruction.
    always_comb begin
        case (res_sel)
            2'b00:   pipe_data = alu_out;
            2'b01:   pipe_data = load_val;
            2'b10:   pipe_data = pc_plus4;
            2'b11:   pipe_data = immediate;
            default: pipe_data = alu_out;
        endcase
    end

    // Slot arbitration: pipeline first, then buffered divide, then direct divide bypass.
    always_comb begin
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        buf_valid_d = buf_valid_q;
        buf_rd_d    = buf_rd_q;
        buf_data_d  = buf_data_q;
        if (pipe_w) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd;
            rf_wdata_d = pipe_data;
            if (!buf_valid_q && div_keep) begin
                buf_valid_d = 1'b1;
                buf_rd_d    = div_rd;
                buf_data_d  = div_result;
            end else begin
                buf_valid_d = buf_valid_q;
            end
        end else if (buf_valid_q) begin
            rf_we_d     = 1'b1;
            rf_waddr_d  = buf_rd_q;
            rf_wdata_d  = buf_data_q;
            buf_valid_d = div_keep;
            if (div_keep) begin
                buf_rd_d   = div_rd;
                buf_data_d = div_result;
            end else begin
                buf_rd_d   = buf_rd_q;
            end
        end else if (div_keep) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = div_rd;
            rf_wdata_d = div_result;
        end else begin
            rf_we_d    = 1'b0;
        end
    end

    // Writeback register and divide buffer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= {RADDR_W{1'b0}};
            rf_wdata_q  <= {XLEN{1'b0}};
            buf_valid_q <= 1'b0;
            buf_rd_q    <= {RADDR_W{1'b0}};
            buf_data_q  <= {XLEN{1'b0}};
        end else begin
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            buf_valid_q <= buf_valid_d;
            buf_rd_q    <= buf_rd_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign rf_we          = rf_we_q;
    assign rf_waddr       = rf_waddr_q;
    assign rf_wdata       = rf_wdata_q;
    assign div_pending    = buf_valid_q;
    assign div_pending_rd = buf_rd_q;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] instret_d, instret_q;

    // Retire count covers every unflushed valid instruction, writing rd or not.
    always_comb begin
        if (mem_valid && !flush) begin
            instret_d = instret_q + 64'd1;
        end else begin
            instret_d = instret_q;
        end
    end

    // Retire counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= 64'd0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage_buffered.sv
// Scoreboard bench for wb_stage_buffered (XLEN=32): directed test-plan cases then randomized traffic.
module tb_wb_stage_buffered;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, flush, reg_write;
    logic [4:0]  rd;
    logic [1:0]  res_sel;
    logic [31:0] alu_out, pc_plus4, immediate, mem_rdata;
    logic [1:0]  byte_off;
    logic [2:0]  ld_funct3;
    logic        div_valid;
    logic [4:0]  div_rd;
    logic [31:0] div_result;
    logic        div_ready, div_pending;
    logic [4:0]  div_pending_rd;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] instret;
    longint unsigned m_instret = 0;
`endif

    wb_stage_buffered dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .flush(flush), .reg_write(reg_write),
        .rd(rd), .res_sel(res_sel), .alu_out(alu_out), .pc_plus4(pc_plus4),
        .immediate(immediate), .mem_rdata(mem_rdata), .byte_off(byte_off),
        .ld_funct3(ld_funct3), .div_valid(div_valid), .div_rd(div_rd),
        .div_result(div_result), .div_ready(div_ready), .div_pending(div_pending),
        .div_pending_rd(div_pending_rd),
`ifdef WB_RETIRE_CNT_EN
        .instret(instret),
`endif
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t  expq[$];
    int   edge_n = 0;
    int   total = 0;
    int   bad = 0;

    // Reference state: one-deep buffer and the divider's offered result.
    bit          m_buf_has = 1'b0;
    logic [4:0]  m_buf_rd;
    logic [31:0] m_buf_data;
    bit          src_has = 1'b0;
    logic [4:0]  src_rd = 5'd0;
    logic [31:0] src_data = 32'd0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ld_ref(input logic [31:0] w, input int off, input logic [2:0] f3);
        int unsigned b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (8 * ((off / 2) * 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] pipe_ref();
        case (res_sel)
            2'd0:    return alu_out;
            2'd1:    return ld_ref(mem_rdata, int'(byte_off), ld_funct3);
            2'd2:    return pc_plus4;
            default: return immediate;
        endcase
    endfunction

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.n = edge_n + 1;
        e.a = a;
        e.d = d;
        expq.push_back(e);
    endtask

    task automatic take_src_to_buf();
        if (src_rd != 5'd0) begin
            m_buf_has  = 1'b1;
            m_buf_rd   = src_rd;
            m_buf_data = src_data;
        end
        src_has = 1'b0;
    endtask

    // One cycle: called at a negedge with pipeline inputs already set.
    task automatic step(input bit do_rst);
        bit pw;
        chk("div_pending", {63'd0, div_pending}, {63'd0, m_buf_has});
        if (m_buf_has) chk("div_pending_rd", {59'd0, div_pending_rd}, {59'd0, m_buf_rd});
`ifdef WB_RETIRE_CNT_EN
        chk("instret", instret, m_instret);
`endif
        rst        = do_rst;
        div_valid  = src_has;
        div_rd     = src_rd;
        div_result = src_data;
        #1;
        pw = mem_valid && !flush && reg_write && (rd != 5'd0);
        chk("div_ready", {63'd0, div_ready}, {63'd0, (!m_buf_has || !pw)});
        if (do_rst) begin
            m_buf_has = 1'b0;
            src_has   = 1'b0;
`ifdef WB_RETIRE_CNT_EN
            m_instret = 0;
`endif
        end else begin
`ifdef WB_RETIRE_CNT_EN
            if (mem_valid && !flush) m_instret++;
`endif
            if (pw) begin
                push(rd, pipe_ref());
                if (src_has && !m_buf_has) take_src_to_buf();
            end else if (m_buf_has) begin
                push(m_buf_rd, m_buf_data);
                m_buf_has = 1'b0;
                if (src_has) take_src_to_buf();
            end else if (src_has) begin
                if (src_rd != 5'd0) push(src_rd, src_data);
                src_has = 1'b0;
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0; flush = 1'b0; reg_write = 1'b0; rd = 5'd0; res_sel = 2'd0;
        alu_out = 32'd0; pc_plus4 = 32'd0; immediate = 32'd0; mem_rdata = 32'd0;
        byte_off = 2'd0; ld_funct3 = 3'd0;
    endtask

    task automatic pipe_inputs(input logic [4:0] r, input logic [1:0] rs);
        mem_valid = 1'b1; flush = 1'b0; reg_write = 1'b1; rd = r; res_sel = rs;
    endtask

    // Monitor: every rf_we must match the oldest expected write for this edge.
    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].n < edge_n) begin
            total++;
            bad++;
            $display("FAIL missed_write: rf_we=0 expected write x%0d=0x%0h", expq[0].a, expq[0].d);
            void'(expq.pop_front());
        end
        if (rf_we) begin
            if (expq.size() > 0 && expq[0].n == edge_n) begin
                wr_t e;
                e = expq.pop_front();
                chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, e.a});
                chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, e.d});
            end else begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got x%0d=0x%0h expected no write", rf_waddr, rf_wdata);
            end
        end
    end

    initial begin
        idle_inputs();
        rst = 1'b1; div_valid = 1'b0; div_rd = 5'd0; div_result = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_rf_we", {63'd0, rf_we}, 64'd0);
        chk("reset_rf_waddr", {59'd0, rf_waddr}, 64'd0);
        chk("reset_rf_wdata", {32'd0, rf_wdata}, 64'd0);
        chk("reset_pending", {63'd0, div_pending}, 64'd0);
        chk("reset_pending_rd", {59'd0, div_pending_rd}, 64'd0);
        chk("reset_ready", {63'd0, div_ready}, 64'd1);
        rst = 1'b0;

        // Load extraction cases.
        pipe_inputs(5'd5, 2'd1); mem_rdata = 32'h80FF_7F01; byte_off = 2'd3; ld_funct3 = 3'b000;
        step(1'b0);
        chk("lb_we", {63'd0, rf_we}, 64'd1);
        chk("lb_data", {32'd0, rf_wdata}, 64'hFFFF_FF80);
        byte_off = 2'd2; ld_funct3 = 3'b101;
        step(1'b0);
        chk("lhu_data", {32'd0, rf_wdata}, 64'h0000_80FF);
        ld_funct3 = 3'b001;
        step(1'b0);
        chk("lh_data", {32'd0, rf_wdata}, 64'hFFFF_80FF);

        // Contention: pipeline busy, divide results queue behind it.
        pipe_inputs(5'd3, 2'd0); alu_out = 32'h0000_0333;
        src_has = 1'b1; src_rd = 5'd7; src_data = 32'h2A;
        step(1'b0);
        chk("cont_pending", {63'd0, div_pending}, 64'd1);
        src_has = 1'b1; src_rd = 5'd8; src_data = 32'h55;
        #1 chk("cont_ready_low", {63'd0, div_ready}, 64'd0);
        step(1'b0);
        idle_inputs();
        step(1'b0);
        chk("cont_drain_addr", {59'd0, rf_waddr}, 64'd7);
        chk("cont_drain_data", {32'd0, rf_wdata}, 64'h2A);
        step(1'b0);

        // Flush and x0.
        pipe_inputs(5'd9, 2'd0); flush = 1'b1;
        step(1'b0);
        chk("flush_no_we", {63'd0, rf_we}, 64'd0);
        pipe_inputs(5'd0, 2'd0);
        step(1'b0);
        chk("x0_no_we", {63'd0, rf_we}, 64'd0);

        // Direct bypass with an idle pipeline.
        idle_inputs();
        src_has = 1'b1; src_rd = 5'd12; src_data = 32'h1234;
        step(1'b0);
        chk("bypass_addr", {59'd0, rf_waddr}, 64'd12);
        chk("bypass_data", {32'd0, rf_wdata}, 64'h1234);
        chk("bypass_pending", {63'd0, div_pending}, 64'd0);

        // Reset with a full buffer.
        pipe_inputs(5'd3, 2'd2); pc_plus4 = 32'h0000_1004;
        src_has = 1'b1; src_rd = 5'd20; src_data = 32'hDEAD_BEEF;
        step(1'b0);
        idle_inputs();
        step(1'b1);
        pipe_inputs(5'd3, 2'd0);
        #1;
        chk("rst_pending", {63'd0, div_pending}, 64'd0);
        chk("rst_we", {63'd0, rf_we}, 64'd0);
        chk("rst_ready", {63'd0, div_ready}, 64'd1);
        idle_inputs();
        step(1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            mem_valid = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 9) < 2);
            reg_write = ($urandom_range(0, 9) < 8);
            rd        = 5'($urandom_range(0, 31));
            res_sel   = 2'($urandom_range(0, 3));
            alu_out   = $urandom; pc_plus4 = $urandom; immediate = $urandom; mem_rdata = $urandom;
            byte_off  = 2'($urandom_range(0, 3));
            ld_funct3 = 3'($urandom_range(0, 7));
            if (!src_has && $urandom_range(0, 9) < 3) begin
                src_has  = 1'b1;
                src_rd   = 5'($urandom_range(0, 31));
                src_data = $urandom;
            end
            step((i % 997) == 500);
        end

        idle_inputs();
        for (int i = 0; i < 4; i++) step(1'b0);
        @(negedge clk);
        chk("scoreboard_empty", 64'(expq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
